fft8_seq_ctrl: RTL and testbench



---
 rtl/fft8_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fft8_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: sequencer for the free-running 3-stage radix-2 8-point FFT.
// Tracks which of the 8 input samples have been written, launches a frame
// on start, counts pipeline latency, pulses result capture and keeps
// busy/done/err_start status for software polling.
// Optional feature macro: FFT_SEQ_AUTORUN_EN. When defined, the write that
// completes the sample mask in IDLE or DONE launches a frame by itself.
module fft8_seq_ctrl #(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_we,
    input  logic [2:0]         sample_idx,
    input  logic               start,
    input  logic               done_clr,
    input  logic               err_clr,
    output logic               launch,
    output logic               cap_en,
    output logic               busy,
    output logic               done,
    output logic               err_start,
    output logic [7:0]         loaded_mask,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_LAT - 1);

    logic [1:0]         state_q, state_d;
    logic               launch_q, launch_d;
    logic               cap_en_q, cap_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         mask_q, mask_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [7:0]         we_bit;
    logic [7:0]         mask_wr;
    logic               idle_or_done;
    logic               start_go;
    logic               auto_go;
    logic               launch_go;
    logic               start_rej;

    // One-hot of the sample being written this cycle
    always_comb begin
        we_bit = '0;
        if (sample_we) begin
            we_bit[sample_idx] = 1'b1;
        end
    end

    // Launch decision: explicit start, and optionally mask completion
    always_comb begin
        idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
        mask_wr      = mask_q | we_bit;
        start_go     = start && idle_or_done && (mask_q == 8'hFF);
`ifdef FFT_SEQ_AUTORUN_EN
        auto_go      = idle_or_done && (mask_q != 8'hFF) && (mask_wr == 8'hFF);
`else
        auto_go      = 1'b0;
`endif
        launch_go    = start_go || auto_go;
        // A start that coincides with an automatic launch is not an error
        start_rej    = start && !launch_go;
    end

    // Next-state and status update
    always_comb begin
        state_d  = state_q;
        launch_d = 1'b0;
        cap_en_d = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;

        // An accepted start clears the mask, but a write in the same cycle
        // still lands and belongs to the next frame. An automatic launch is
        // triggered by that very write, so its bit is consumed.
        if (start_go) begin
            mask_d = we_bit;
        end else if (auto_go) begin
            mask_d = '0;
        end else begin
            mask_d = mask_wr;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch_go) begin
                    state_d  = ST_RUN;
                    launch_d = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    cnt_d    = CNT_LOAD;
                // done_clr is ignored in the first DONE cycle (cap_en still
                // high) so a clear coincident with the capture loses.
                end else if ((state_q == ST_DONE) && done_clr && !cap_en_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    cap_en_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    frame_d  = frame_q + FRAME_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (start_rej) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            cap_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mask_q   <= '0;
            frame_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            cap_en_q <= cap_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
        end
    end

    assign launch      = launch_q;
    assign cap_en      = cap_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_start   = err_q;
    assign loaded_mask = mask_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed bench for fft8_seq_ctrl. Captures are scoreboarded: the expected
// capture cycle and frame count are queued when a launching stimulus is
// driven and popped by a monitor whenever cap_en is seen.
module tb_fft8_seq_ctrl;

    localparam int unsigned PL = 3;
    localparam int unsigned FW = 3;

    typedef struct {
        int unsigned cyc;
        logic [FW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_we;
    logic [2:0]    sample_idx;
    logic          start;
    logic          done_clr;
    logic          err_clr;
    logic          launch;
    logic          cap_en;
    logic          busy;
    logic          done;
    logic          err_start;
    logic [7:0]    loaded_mask;
    logic [FW-1:0] frame_cnt;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    int unsigned   cyc = 0;
    logic [FW-1:0] mfc = '0;
    exp_t          exp_q[$];
    exp_t          mon_e;

    fft8_seq_ctrl #(.PIPE_LAT(PL), .CNT_W(4), .FRAME_W(FW)) dut (
        .clk(clk), .rst(rst), .sample_we(sample_we), .sample_idx(sample_idx),
        .start(start), .done_clr(done_clr), .err_clr(err_clr),
        .launch(launch), .cap_en(cap_en), .busy(busy), .done(done),
        .err_start(err_start), .loaded_mask(loaded_mask), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture monitor: every cap_en must match a queued expectation
    always @(negedge clk) begin
        if (cap_en) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL cap_unexpected: observed cap_en=1 at cycle %0d, expected no capture", cyc);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                total++;
                assert (cyc === mon_e.cyc) else begin
                    bad++;
                    $error("FAIL cap_cycle: observed %0d expected %0d", cyc, mon_e.cyc);
                end
                total++;
                assert (frame_cnt === mon_e.fc) else begin
                    bad++;
                    $error("FAIL cap_frame_cnt: observed %0d expected %0d", frame_cnt, mon_e.fc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_launch"}, launch, 1'b0);
        chk1({tag, "_cap_en"}, cap_en, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err_start, 1'b0);
        chk8({tag, "_mask"}, loaded_mask, 8'h00);
        chkf({tag, "_frame"}, frame_cnt, '0);
    endtask

    // Queue the capture expected from a launching edge driven now
    task automatic push_frame();
        exp_t e;
        mfc = mfc + FW'(1);
        e.cyc = cyc + 1 + PL;
        e.fc = mfc;
        exp_q.push_back(e);
    endtask

    task automatic wr(input int unsigned idx);
        sample_we = 1'b1;
        sample_idx = idx[2:0];
        tick();
        sample_we = 1'b0;
    endtask

    // Load all eight samples and launch; ends at the launch cycle
    task automatic load_and_go();
        for (int unsigned i = 0; i < 7; i++) wr(i);
`ifdef FFT_SEQ_AUTORUN_EN
        push_frame();
        wr(7);
`else
        wr(7);
        chk1("no_auto_launch", launch, 1'b0);
        chk8("mask_full", loaded_mask, 8'hFF);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
`endif
        chk1("launch", launch, 1'b1);
        chk1("launch_busy", busy, 1'b1);
        chk1("launch_done", done, 1'b0);
        chk8("launch_mask", loaded_mask, 8'h00);
    endtask

    // From the launch cycle, step to the capture cycle checking status
    task automatic finish_frame();
        for (int unsigned k = 1; k < PL; k++) begin
            tick();
            chk1("run_busy", busy, 1'b1);
            chk1("run_launch", launch, 1'b0);
        end
        tick();
        chk1("cap_done", done, 1'b1);
        chk1("cap_busy", busy, 1'b0);
        chkf("cap_frame", frame_cnt, mfc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sample_we = 1'b0;
        sample_idx = '0;
        start = 1'b0;
        done_clr = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // Basic frame, then done_clr against capture and a plain done_clr
        load_and_go();
        finish_frame();
        done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        chk1("done_clr_vs_cap", done, 1'b1);
        done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        chk1("done_clr", done, 1'b0);

        // Incomplete mask rejects start; err_clr and its collision
        for (int unsigned i = 0; i < 7; i++) wr(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("rej_no_launch", launch, 1'b0);
        chk1("rej_err", err_start, 1'b1);
        chk1("rej_busy", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("err_clr", err_start, 1'b0);
        start = 1'b1;
        err_clr = 1'b1;
        tick();
        start = 1'b0;
        err_clr = 1'b0;
        chk1("err_set_wins", err_start, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("err_clr2", err_start, 1'b0);
`ifdef FFT_SEQ_AUTORUN_EN
        push_frame();
        wr(7);
`else
        wr(7);
        chk1("wr7_no_launch", launch, 1'b0);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
`endif
        chk1("launch2", launch, 1'b1);

        // Start and done_clr while in RUN
        start = 1'b1;
        done_clr = 1'b1;
        tick();
        start = 1'b0;
        done_clr = 1'b0;
        chk1("busy_start_err", err_start, 1'b1);
        chk1("busy_start_busy", busy, 1'b1);
        chk1("busy_start_no_launch", launch, 1'b0);
        for (int unsigned k = 2; k < PL; k++) begin
            tick();
            chk1("run2_busy", busy, 1'b1);
        end
        tick();
        chk1("cap2_done", done, 1'b1);
        chkf("cap2_frame", frame_cnt, mfc);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("err_clr3", err_start, 1'b0);

        // Restart from DONE without done_clr
        load_and_go();
        finish_frame();

        // Write coinciding with launch, then reset mid-frame (no push: aborted)
`ifdef FFT_SEQ_AUTORUN_EN
        for (int unsigned i = 0; i < 8; i++) wr(i);
        chk1("auto_launch", launch, 1'b1);
        chk8("auto_mask", loaded_mask, 8'h00);
`else
        for (int unsigned i = 0; i < 8; i++) wr(i);
        chk8("mask_full2", loaded_mask, 8'hFF);
        start = 1'b1;
        sample_we = 1'b1;
        sample_idx = 3'd5;
        tick();
        start = 1'b0;
        sample_we = 1'b0;
        chk1("launch_we", launch, 1'b1);
        chk8("write_wins_mask", loaded_mask, 8'h20);
`endif
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        mfc = '0;
        tick();
        tick();
        rst = 1'b0;
        repeat (PL + 3) tick();
        chk1("post_rst_done", done, 1'b0);
        chkf("post_rst_frame", frame_cnt, '0);

        // Eight frames: frame_cnt wraps back to zero
        for (int unsigned f = 0; f < 8; f++) begin
            load_and_go();
            finish_frame();
        end
        chkf("wrap_frame", frame_cnt, '0);

        repeat (PL + 2) tick();
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL pending_caps: observed %0d outstanding expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
